// File: rtl/wshb_arbiter3_if.sv
// Wishbone B4 bus bundle shared by the three requesters and the SDRAM-side master path.
interface wshb_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADR_W      = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADR_W-1:0]        adr;
  logic [DATA_BYTES*8-1:0] dat_ms;
  logic [DATA_BYTES*8-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  input  dat_sm, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
                  output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arbiter3.sv
// Three-way round-robin Wishbone arbiter (mire / stream / vga -> SDRAM) with
// ack-count based burst preemption.

module wshb_arb_resp (
  input  logic en,
  input  logic m_ack,
  input  logic m_err,
  input  logic m_rty,
  output logic ack,
  output logic err,
  output logic rty
);
  assign ack = en & m_ack;
  assign err = en & m_err;
  assign rty = en & m_rty;
endmodule

module wshb_arbiter3 #(
  parameter int MAX_BURST = 64
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  wshb_if.slave      wshb_ifs_mire,
  wshb_if.slave      wshb_ifs_stream,
  wshb_if.slave      wshb_ifs_vga,
  wshb_if.master     wshb_ifm,
  output logic [1:0] grant
);
  localparam int NUM_REQ = 3;
  localparam int CW      = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  localparam logic [1:0] NONE     = 2'd0;
  localparam logic [1:0] G_MIRE   = 2'd1;
  localparam logic [1:0] G_STREAM = 2'd2;
  localparam logic [1:0] G_VGA    = 2'd3;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } wb_req_t;

  wb_req_t [NUM_REQ-1:0] req;
  wb_req_t               fwd;
  logic [NUM_REQ-1:0]    cyc_vec;
  logic [NUM_REQ-1:0]    own_mask;
  logic [NUM_REQ-1:0]    resp_en;
  logic [NUM_REQ-1:0]    r_ack, r_err, r_rty;

  logic [1:0]    st, st_nxt;
  logic [1:0]    last;
  logic [1:0]    own;
  logic [2:0]    pick;
  logic [CW-1:0] cnt, cnt_eff;
  logic          ack_fwd;
  logic          preempt;

  assign req[0] = {wshb_ifs_mire.cyc, wshb_ifs_mire.stb, wshb_ifs_mire.we,
                   wshb_ifs_mire.adr, wshb_ifs_mire.dat_ms, wshb_ifs_mire.sel,
                   wshb_ifs_mire.cti, wshb_ifs_mire.bte};
  assign req[1] = {wshb_ifs_stream.cyc, wshb_ifs_stream.stb, wshb_ifs_stream.we,
                   wshb_ifs_stream.adr, wshb_ifs_stream.dat_ms, wshb_ifs_stream.sel,
                   wshb_ifs_stream.cti, wshb_ifs_stream.bte};
  assign req[2] = {wshb_ifs_vga.cyc, wshb_ifs_vga.stb, wshb_ifs_vga.we,
                   wshb_ifs_vga.adr, wshb_ifs_vga.dat_ms, wshb_ifs_vga.sel,
                   wshb_ifs_vga.cti, wshb_ifs_vga.bte};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cyc
    assign cyc_vec[i] = req[i].cyc;
    assign resp_en[i] = !sys_rst && (st == 2'(i + 1));
  end

  // Search ptr+1, ptr+2, ptr+3 (mod 3); returns {found, index}, nearest wins.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] mask);
    logic [2:0] r;
    logic [2:0] s;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 1; i--) begin
      s   = {1'b0, ptr} + 3'(i);
      idx = (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign own      = st - 2'd1;
  assign own_mask = (st == NONE) ? 3'b000 : (3'b001 << own);

  // Reset gates the bus immediately so nothing leaks out before the state clears.
  always_comb begin
    fwd = '0;
    if (!sys_rst && st != NONE) fwd = req[own];
  end

  assign wshb_ifm.cyc    = fwd.cyc;
  assign wshb_ifm.stb    = fwd.stb;
  assign wshb_ifm.we     = fwd.we;
  assign wshb_ifm.adr    = fwd.adr;
  assign wshb_ifm.dat_ms = fwd.dat;
  assign wshb_ifm.sel    = fwd.sel;
  assign wshb_ifm.cti    = fwd.cti;
  assign wshb_ifm.bte    = fwd.bte;

  assign ack_fwd = fwd.cyc & fwd.stb & wshb_ifm.ack;
  assign cnt_eff = (ack_fwd && cnt != CMAX) ? cnt + CW'(1) : cnt;

  // Switch only once the current beat is acked or the owner is idling stb.
  assign preempt = (MAX_BURST != 0) && (cnt_eff == CMAX) &&
                   (|(cyc_vec & ~own_mask)) && (ack_fwd || !fwd.stb);

  always_comb begin
    st_nxt = st;
    pick   = 3'b000;
    if (st == NONE) begin
      pick = rr_pick(last, cyc_vec);
      if (pick[2]) st_nxt = pick[1:0] + 2'd1;
    end else if (!cyc_vec[own] || preempt) begin
      pick   = rr_pick(own, cyc_vec & ~own_mask);
      st_nxt = pick[2] ? pick[1:0] + 2'd1 : NONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st   <= NONE;
      last <= 2'd2;
      cnt  <= '0;
    end else begin
      st <= st_nxt;
      if (st_nxt != st) cnt <= '0;
      else if (st != NONE) cnt <= cnt_eff;
      if (st_nxt != NONE && st_nxt != st) last <= st_nxt - 2'd1;
    end
  end

  assign grant = st;

  wshb_arb_resp u_resp [NUM_REQ-1:0] (
    .en    (resp_en),
    .m_ack (wshb_ifm.ack),
    .m_err (wshb_ifm.err),
    .m_rty (wshb_ifm.rty),
    .ack   (r_ack),
    .err   (r_err),
    .rty   (r_rty)
  );

  assign wshb_ifs_mire.ack   = r_ack[0];
  assign wshb_ifs_mire.err   = r_err[0];
  assign wshb_ifs_mire.rty   = r_rty[0];
  assign wshb_ifs_stream.ack = r_ack[1];
  assign wshb_ifs_stream.err = r_err[1];
  assign wshb_ifs_stream.rty = r_rty[1];
  assign wshb_ifs_vga.ack    = r_ack[2];
  assign wshb_ifs_vga.err    = r_err[2];
  assign wshb_ifs_vga.rty    = r_rty[2];

  assign wshb_ifs_mire.dat_sm   = wshb_ifm.dat_sm;
  assign wshb_ifs_stream.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs_vga.dat_sm    = wshb_ifm.dat_sm;

  // grant_unused guard: G_* names document the state encoding used by grant.
  logic unused_ok;
  assign unused_ok = (G_MIRE != G_STREAM) && (G_VGA != NONE);
endmodule

// File: doc/wshb_arbiter3.md
WSHB_ARBITER3 -- requirements
Module: wshb_arbiter3

Interface
REQ-001 SHALL have parameter MAX_BURST, default 64, meaning max acked transfers per grant before preemption when others request; 0 disables preemption.
REQ-002 SHALL have port sys_clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port wshb_ifs_mire  wshb_if.slave  DATA_BYTES=4  requester 0 (pattern writer).
REQ-005 SHALL have port wshb_ifs_stream  wshb_if.slave  DATA_BYTES=4  requester 1 (video stream writer).
REQ-006 SHALL have port wshb_ifs_vga  wshb_if.slave  DATA_BYTES=4  requester 2 (display reader).
REQ-007 SHALL have port wshb_ifm  wshb_if.master  DATA_BYTES=4  shared path to SDRAM controller.
REQ-008 SHALL have port grant  output  2  current owner: 0 none, 1 mire, 2 stream, 3 vga.

Function
REQ-009 SHALL hold a registered grant state: NONE, G_MIRE, G_STREAM, G_VGA.
REQ-010 SHALL hold a registered last-owner pointer (2 bits) for round-robin; search order after owner k is k+1, k+2, k+3 (mod 3).
REQ-011 NONE -> grant first requester (cyc=1) in round-robin order at next edge; stay NONE if no cyc.
REQ-012 In G_k with cyc_k=0 -> next edge grants next requester in round-robin order excluding k, else NONE; no idle cycle between owners.
REQ-013 In G_k with cyc_k=1 SHALL stay unless preemption (REQ-016) fires.
REQ-014 SHALL forward cyc, stb, we, adr, dat_ms, sel, cti, bte of the granted requester combinationally to wshb_ifm; in NONE drive cyc=0, stb=0, all other fields 0.
REQ-015 SHALL route wshb_ifm ack, err, rty only to the granted requester; all others see ack=err=rty=0; dat_sm broadcast to all three.
REQ-016 SHALL count acks during a grant (counter width clog2(MAX_BURST+1)); when count==MAX_BURST, MAX_BURST!=0 and another requester has cyc=1, next edge switches grant per REQ-012 even if cyc_k=1.
REQ-017 After preemption the preempted requester SHALL see stb blocked (no ack) and re-enters round-robin as normal requester.
REQ-018 Ack counter SHALL clear on every grant change and saturate at MAX_BURST.
REQ-019 Preemption SHALL only take effect at the edge following an ack cycle or an idle-stb cycle; never with an un-acked stb forwarded to wshb_ifm (outstanding transfer completes first).
REQ-020 Last-owner pointer SHALL update to k on each entry to G_k.
REQ-021 grant output SHALL equal the state register encoding; no combinational path from cyc inputs to grant.
REQ-022 Simultaneous cyc from several requesters in NONE: round-robin order decides; single requester always served within one cycle of NONE.
REQ-023 A requester dropping cyc in the same cycle another raises cyc: grant transfers at next edge (REQ-012).

Reset
REQ-024 sys_rst=1 at an edge SHALL force state NONE, last-owner=vga (so mire wins first), ack counter 0.
REQ-025 During and one cycle after reset, wshb_ifm cyc=0, stb=0; all requester ack=err=rty=0; grant=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer without forwarding further stb; no ack delivered to any requester.

Verification
REQ-027 Reset, then mire/stream/vga assert cyc same cycle -> grant 1 next edge; after mire drops cyc, grant 2; after stream drops, grant 3.
REQ-028 MAX_BURST=4, vga holds cyc with stb continuous, SDRAM acks every cycle, mire requests -> after 4th vga ack, grant=1 at next edge; vga sees no ack until regranted.
REQ-029 MAX_BURST=4, vga alone holds cyc for 20 acks -> grant stays 3, 20 acks delivered to vga.
REQ-030 Stream write adr=0x100, dat=0xDEADBEEF, sel=0xF while granted -> wshb_ifm shows identical fields same cycle; mire and vga ack stay 0.
REQ-031 sys_rst pulsed while grant=2 with stb pending -> next cycle grant=0, wshb_ifm cyc=0, stream ack=0.
REQ-032 MAX_BURST=0, vga holds cyc, mire requests for 1000 cycles -> grant stays 3 (no preemption).
